// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle IF/ID/EX/MEM/WB step sequencer.
// Drives per-stage enable strobes, handshakes with instruction/data memory,
// skips MEM for non-memory ops and WB for stores/branches, and stops on
// ECALL (HALT) or on a memory handshake timeout (ERROR).
// Optional: define PERF_COUNTERS_EN to build the cycle/instret counters;
// otherwise cycle_cnt and instret_cnt are tied to zero.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | imem_req asserted, waiting for imem_ready
// DECODE    | ID_en strobe; ECALL diverts to HALT
// EXECUTE   | EX_en strobe; branch retires here
// MEMORY    | dmem_req asserted, waiting for dmem_ready; store retires
// WRITEBACK | wb_en + PC_en strobe (retire)
// HALT      | sticky ECALL stop
// ERROR     | sticky memory timeout

module stage_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [6:0]       IF_op,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             stall_req,
  output logic             imem_req,
  output logic             IF_ir_en,
  output logic             ID_en,
  output logic             EX_en,
  output logic             dmem_req,
  output logic             wb_en,
  output logic             PC_en,
  output logic [2:0]       state,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  // Wait counter holds the number of ready-less request cycles already seen;
  // reaching the last allowed value with ready still low means timeout.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_tmo;
  logic [7:0] w_tmo_next;
  logic       r_is_store;
  logic       w_is_store_next;

  // State, wait counter and memory-op kind registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tmo      <= '0;
      r_is_store <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tmo      <= w_tmo_next;
      r_is_store <= w_is_store_next;
    end
  end

  // Next-state decode plus the handshake/stall-gated strobes.
  always_comb begin
    w_next          = r_state;
    w_tmo_next      = r_tmo;
    w_is_store_next = r_is_store;
    IF_ir_en        = 1'b0;
    ID_en           = 1'b0;
    EX_en           = 1'b0;
    wb_en           = 1'b0;
    PC_en           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        // ready on the final allowed cycle still wins over the timeout
        if (imem_ready) begin
          IF_ir_en = 1'b1;
          w_next   = S_DECODE;
        end else if (r_tmo == TMO_LAST) begin
          w_next = S_ERROR;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
      end
      S_DECODE: begin
        if (!stall_req) begin
          ID_en  = 1'b1;
          w_next = (IF_op == OP_ECALL) ? S_HALT : S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (!stall_req) begin
          EX_en = 1'b1;
          if (IF_op == OP_LOAD || IF_op == OP_STORE) begin
            w_next          = S_MEMORY;
            w_is_store_next = (IF_op == OP_STORE);
          end else if (IF_op == OP_BRANCH) begin
            PC_en  = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_next = S_WRITEBACK;
          end
        end
      end
      S_MEMORY: begin
        if (dmem_ready) begin
          if (r_is_store) begin
            PC_en  = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_next = S_WRITEBACK;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_next = S_ERROR;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
      end
      S_WRITEBACK: begin
        if (!stall_req) begin
          wb_en  = 1'b1;
          PC_en  = 1'b1;
          w_next = S_FETCH;
        end
      end
      default: begin
      end
    endcase
    // any state change starts a fresh wait window for FETCH/MEMORY
    if (w_next != r_state) w_tmo_next = '0;
  end

  assign state       = r_state;
  assign imem_req    = (r_state == S_FETCH);
  assign dmem_req    = (r_state == S_MEMORY);
  assign halted      = (r_state == S_HALT);
  assign timeout_err = (r_state == S_ERROR);

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;
  logic             w_active;

  assign w_active = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_ERROR);

  // Free-running wrap-around counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (w_active) r_cycle_cnt   <= r_cycle_cnt + 1'b1;
      if (PC_en)    r_instret_cnt <= r_instret_cnt + 1'b1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized bench for stage_sequencer. Each instruction is expanded into a
// cycle-by-cycle expectation list from its class, memory wait counts and
// stall lengths; inputs and expected outputs are then replayed against the DUT.
module tb_stage_sequencer;

  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 32;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXECUTE = 3,
                 ST_MEMORY = 4, ST_WRITEBACK = 5, ST_HALT = 6, ST_ERROR = 7;

  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_ECALL = 7'b1110011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [6:0]       IF_op = '0;
  logic             imem_ready = 1'b0;
  logic             dmem_ready = 1'b0;
  logic             stall_req = 1'b0;
  logic             imem_req, IF_ir_en, ID_en, EX_en, dmem_req, wb_en, PC_en;
  logic [2:0]       state;
  logic             halted, timeout_err;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  stage_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .IF_op(IF_op),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .stall_req(stall_req),
    .imem_req(imem_req), .IF_ir_en(IF_ir_en), .ID_en(ID_en), .EX_en(EX_en),
    .dmem_req(dmem_req), .wb_en(wb_en), .PC_en(PC_en), .state(state),
    .halted(halted), .timeout_err(timeout_err),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  typedef struct {
    logic       start, imem_ready, dmem_ready, stall;
    logic [6:0] op;
    int         st;
    logic       ir_en, id_en, ex_en, wb_en, pc_en;
  } cyc_t;

  cyc_t             q[$];
  logic [CNT_W-1:0] m_cyc, m_ret;
  int               n_checks = 0;
  int               n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // one cycle in state st with unconstrained don't-care inputs, no strobes
  function automatic cyc_t blank(input int st, input logic [6:0] op);
    cyc_t c;
    c.start      = 1'($urandom_range(0, 1));
    c.imem_ready = 1'($urandom_range(0, 1));
    c.dmem_ready = 1'($urandom_range(0, 1));
    c.stall      = 1'($urandom_range(0, 1));
    c.op         = op;
    c.st         = st;
    c.ir_en = 0; c.id_en = 0; c.ex_en = 0; c.wb_en = 0; c.pc_en = 0;
    return c;
  endfunction

  task automatic gen_idle(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(ST_IDLE, OP_ADDI); c.start = 0; q.push_back(c);
    end
    c = blank(ST_IDLE, OP_ADDI); c.start = 1; q.push_back(c);
  endtask

  task automatic gen_stop(input int st, input logic [6:0] op);
    for (int i = 0; i < 4; i++) q.push_back(blank(st, op));
  endtask

  // iw/dw: ready-less wait cycles before ready (>= MEM_TIMEOUT means never)
  // sd/se/sw: stall cycles in DECODE / EXECUTE / WRITEBACK
  task automatic gen_instr(input logic [6:0] op, input int iw, input int dw,
                           input int sd, input int se, input int sw, output bit stopped);
    cyc_t c;
    stopped = 0;
    if (iw >= MEM_TIMEOUT) begin
      for (int k = 0; k < MEM_TIMEOUT; k++) begin
        c = blank(ST_FETCH, op); c.imem_ready = 0; q.push_back(c);
      end
      gen_stop(ST_ERROR, op); stopped = 1; return;
    end
    for (int k = 0; k <= iw; k++) begin
      c = blank(ST_FETCH, op); c.imem_ready = (k == iw); c.ir_en = (k == iw); q.push_back(c);
    end
    for (int k = 0; k < sd; k++) begin
      c = blank(ST_DECODE, op); c.stall = 1; q.push_back(c);
    end
    c = blank(ST_DECODE, op); c.stall = 0; c.id_en = 1; q.push_back(c);
    if (op == OP_ECALL) begin
      gen_stop(ST_HALT, op); stopped = 1; return;
    end
    for (int k = 0; k < se; k++) begin
      c = blank(ST_EXECUTE, op); c.stall = 1; q.push_back(c);
    end
    c = blank(ST_EXECUTE, op); c.stall = 0; c.ex_en = 1; c.pc_en = (op == OP_BEQ); q.push_back(c);
    if (op == OP_BEQ) return;
    if (op == OP_LW || op == OP_SW) begin
      if (dw >= MEM_TIMEOUT) begin
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
          c = blank(ST_MEMORY, op); c.dmem_ready = 0; q.push_back(c);
        end
        gen_stop(ST_ERROR, op); stopped = 1; return;
      end
      for (int k = 0; k <= dw; k++) begin
        c = blank(ST_MEMORY, op); c.dmem_ready = (k == dw);
        c.pc_en = (k == dw) && (op == OP_SW); q.push_back(c);
      end
      if (op == OP_SW) return;
    end
    for (int k = 0; k < sw; k++) begin
      c = blank(ST_WRITEBACK, op); c.stall = 1; q.push_back(c);
    end
    c = blank(ST_WRITEBACK, op); c.stall = 0; c.wb_en = 1; c.pc_en = 1; q.push_back(c);
  endtask

  task automatic check_counters(input string tag);
`ifdef PERF_COUNTERS_EN
    check_eq({tag, ".cycle_cnt"}, cycle_cnt, m_cyc);
    check_eq({tag, ".instret_cnt"}, instret_cnt, m_ret);
`else
    check_eq({tag, ".cycle_cnt"}, cycle_cnt, '0);
    check_eq({tag, ".instret_cnt"}, instret_cnt, '0);
`endif
  endtask

  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      start = c.start; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
      stall_req = c.stall; IF_op = c.op;
      #1;
      check_eq("state", state, c.st);
      check_eq("imem_req", imem_req, c.st == ST_FETCH);
      check_eq("dmem_req", dmem_req, c.st == ST_MEMORY);
      check_eq("IF_ir_en", IF_ir_en, c.ir_en);
      check_eq("ID_en", ID_en, c.id_en);
      check_eq("EX_en", EX_en, c.ex_en);
      check_eq("wb_en", wb_en, c.wb_en);
      check_eq("PC_en", PC_en, c.pc_en);
      check_eq("halted", halted, c.st == ST_HALT);
      check_eq("timeout_err", timeout_err, c.st == ST_ERROR);
      check_counters("cyc");
      if (c.st >= ST_FETCH && c.st <= ST_WRITEBACK) m_cyc = m_cyc + 1'b1;
      if (c.pc_en) m_ret = m_ret + 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_counters("pre_reset");
    #2 reset = 1'b0;
    #1;
    check_eq("rst.state", state, ST_IDLE);
    check_eq("rst.strobes", {imem_req, IF_ir_en, ID_en, EX_en, dmem_req, wb_en, PC_en}, '0);
    check_eq("rst.sticky", {halted, timeout_err}, '0);
    check_eq("rst.cycle_cnt", cycle_cnt, '0);
    check_eq("rst.instret_cnt", instret_cnt, '0);
    m_cyc = '0; m_ret = '0;
    @(negedge clk);
    start = 0; imem_ready = 0; dmem_ready = 0; stall_req = 0;
    reset = 1'b1;
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] op;
    case ($urandom_range(0, 6))
      0: op = OP_LW;
      1: op = OP_SW;
      2: op = OP_BEQ;
      3: op = OP_JAL;
      4: op = OP_ADDI;
      default: begin
        op = 7'($urandom);
        if (op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_ECALL) op = OP_ADDI;
      end
    endcase
    return op;
  endfunction

  function automatic int pick_wait();
    if ($urandom_range(0, 15) == 0) return $urandom_range(MEM_TIMEOUT - 1, MEM_TIMEOUT);
    return $urandom_range(0, 3);
  endfunction

  initial begin
    bit stopped;
    int n, drop;
    m_cyc = '0; m_ret = '0;
    #3;
    check_eq("init.state", state, ST_IDLE);
    check_eq("init.outs", {imem_req, IF_ir_en, ID_en, EX_en, dmem_req, wb_en, PC_en, halted, timeout_err}, '0);
    check_eq("init.cnt", {cycle_cnt, instret_cnt}, '0);
    @(negedge clk);
    reset = 1'b1;

    // directed: ADDI, LW with 3 dmem waits, SW, BEQ, ALU with 5-cycle EX stall, ECALL
    gen_idle(2);
    gen_instr(OP_ADDI, 0, 0, 0, 0, 0, stopped);
    gen_instr(OP_LW, 0, 3, 0, 0, 0, stopped);
    gen_instr(OP_SW, 0, 0, 0, 0, 0, stopped);
    gen_instr(OP_BEQ, 0, 0, 0, 0, 0, stopped);
    gen_instr(OP_ADDI, 0, 0, 0, 5, 0, stopped);
    gen_instr(OP_ECALL, 0, 0, 0, 0, 0, stopped);
    run_q();
    do_reset();

    // fetch timeout, then ready on the final allowed cycle
    gen_idle(1);
    gen_instr(OP_ADDI, MEM_TIMEOUT, 0, 0, 0, 0, stopped);
    run_q();
    do_reset();
    gen_idle(0);
    gen_instr(OP_ADDI, MEM_TIMEOUT - 1, 0, 0, 0, 0, stopped);
    gen_instr(OP_SW, 0, MEM_TIMEOUT - 1, 1, 1, 0, stopped);
    gen_instr(OP_LW, 1, MEM_TIMEOUT, 0, 0, 0, stopped);
    run_q();
    do_reset();

    // random programs, optionally cut short by a reset mid-instruction
    for (int p = 0; p < 30; p++) begin
      gen_idle($urandom_range(0, 3));
      n = $urandom_range(1, 8);
      stopped = 0;
      for (int i = 0; i < n && !stopped; i++)
        gen_instr(pick_op(), pick_wait(), pick_wait(), $urandom_range(0, 2),
                  $urandom_range(0, 3), $urandom_range(0, 2), stopped);
      if (!stopped && $urandom_range(0, 1) == 1)
        gen_instr(OP_ECALL, $urandom_range(0, 2), 0, $urandom_range(0, 2), 0, 0, stopped);
      if ($urandom_range(0, 2) == 0) begin
        drop = $urandom_range(0, q.size() - 1);
        for (int k = 0; k < drop; k++) void'(q.pop_back());
      end
      run_q();
      do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit at t=%0t", $time);
    $fatal(1);
  end

endmodule
